// File: rtl/dmem_pkg.sv
// Shared encodings, defaults and request payload for the data-memory response block.
package dmem_pkg;

    localparam int unsigned DEF_DEPTH_WORDS = 256;
    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned ST_W            = 2;

    // Access size encodings as presented on req_size
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_RSVD = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_RESP = 2'd2;

    // Internal vectors are descending: addr[31] is the big-endian bit 0 on the port
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
    } dmem_req_t;

    // Reserved size, misalignment or word index beyond the array
    function automatic logic req_error(input dmem_req_t r, input int unsigned depth);
        logic bad;
        bad = 1'b0;
        if (r.size == SIZE_RSVD)                          bad = 1'b1;
        if ((r.size == SIZE_HALF) && r.addr[0])           bad = 1'b1;
        if ((r.size == SIZE_WORD) && (r.addr[1:0] != 2'b00)) bad = 1'b1;
        if ({2'b00, r.addr[31:2]} >= 32'(depth))          bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane logic: store merge into the addressed lanes and load extract/extend.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] merge_c,
    output logic [31:0] rdata_c
);

    logic [3:0]  be;
    logic [31:0] rep;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane 0 is the most significant byte, so it maps to be[3]
    always_comb begin
        be  = 4'b0000;
        rep = wdata;
        case (size)
            SIZE_BYTE: begin
                be  = 4'b1000 >> lane;
                rep = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                be  = lane[1] ? 4'b0011 : 4'b1100;
                rep = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                be  = 4'b1111;
                rep = wdata;
            end
            default: begin
                be  = 4'b0000;
                rep = wdata;
            end
        endcase
    end

    always_comb begin
        merge_c = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merge_c[8*i +: 8] = rep[8*i +: 8];
            end
        end
    end

    always_comb begin
        byte_sel = old_word[31:24];
        case (lane)
            2'd0:    byte_sel = old_word[31:24];
            2'd1:    byte_sel = old_word[23:16];
            2'd2:    byte_sel = old_word[15:8];
            default: byte_sel = old_word[7:0];
        endcase
        half_sel = lane[1] ? old_word[15:0] : old_word[31:16];
    end

    always_comb begin
        rdata_c = '0;
        case (size)
            SIZE_BYTE: rdata_c = {{24{sgn & byte_sel[7]}}, byte_sel};
            SIZE_HALF: rdata_c = {{16{sgn & half_sel[15]}}, half_sel};
            SIZE_WORD: rdata_c = old_word;
            default:   rdata_c = '0;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Data memory with fixed wait states: accepts one load/store, answers with a one-cycle response.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [0:31] req_addr,
    input  logic [0:1]  req_size,
    input  logic        req_signed,
    input  logic [0:31] req_wdata,
    output logic        resp_valid,
    output logic [0:31] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    generate
        if (WAIT_CYCLES > 15) begin : g_bad_wait
            $error("dmem_resp: WAIT_CYCLES must be in 0..15");
        end
        if (DEPTH_WORDS == 0) begin : g_bad_depth
            $error("dmem_resp: DEPTH_WORDS must be non-zero");
        end
    endgenerate

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    dmem_req_t        in_req_c, cur_c;
    logic             err_c, enter_resp_c, wr_en_c;
    logic             ready_d, valid_d, err_d;
    logic [31:0]      rdata_d;
    logic [IDX_W-1:0] idx_c;
    logic [31:0]      old_word_c, merge_c, lane_rdata_c;

    logic [31:0] mem [DEPTH_WORDS];

    always_comb begin
        in_req_c.wr    = req_wr;
        in_req_c.addr  = req_addr;
        in_req_c.size  = req_size;
        in_req_c.sgn   = req_signed;
        in_req_c.wdata = req_wdata;
    end

    // With zero wait states the access completes on the acceptance edge, so use the live request
    assign cur_c   = (state_q == ST_IDLE) ? in_req_c : req_q;
    assign err_c   = req_error(cur_c, DEPTH_WORDS);
    assign idx_c   = cur_c.addr[IDX_W+1:2];
    assign old_word_c = err_c ? 32'd0 : mem[idx_c];

    dmem_lane u_lane (
        .size     (cur_c.size),
        .lane     (cur_c.addr[1:0]),
        .sgn      (cur_c.sgn),
        .wdata    (cur_c.wdata),
        .old_word (old_word_c),
        .merge_c  (merge_c),
        .rdata_c  (lane_rdata_c)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        enter_resp_c = 1'b0;
        ready_d      = 1'b0;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        rdata_d      = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d = in_req_c;
                    if (WAIT_CYCLES == 0) begin
                        state_d      = ST_RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = ST_RESP;
                    enter_resp_c = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp_c) begin
            valid_d = 1'b1;
            err_d   = err_c;
            rdata_d = (err_c || cur_c.wr) ? 32'd0 : lane_rdata_c;
        end
        ready_d = (state_d == ST_IDLE);
    end

    assign wr_en_c = enter_resp_c && cur_c.wr && !err_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            req_ready  <= ready_d;
            resp_valid <= valid_d;
            resp_err   <= err_d;
            resp_rdata <= rdata_d;
        end
    end

    // Storage survives reset; a reset on the commit edge suppresses the store
    always_ff @(posedge clk) begin
        if (!rst && wr_en_c) begin
            mem[idx_c] <= merge_c;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 side instance).
module tb_dmem_resp;

    localparam int unsigned WAIT = 2;
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr, req_signed;
    logic [0:31] req_addr, req_wdata;
    logic [0:1]  req_size;
    logic        resp_valid, resp_err;
    logic [0:31] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_wr, z_req_signed;
    logic [0:31] z_req_addr, z_req_wdata;
    logic [0:1]  z_req_size;
    logic        z_resp_valid, z_resp_err;
    logic [0:31] z_resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_wr(z_req_wr), .req_addr(z_req_addr), .req_size(z_req_size),
        .req_signed(z_req_signed), .req_wdata(z_req_wdata), .resp_valid(z_resp_valid),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rdata", resp_rdata, e.rdata);
                    check("err", 32'(resp_err), 32'(e.err));
                    check("latency", 32'(cyc - e.acc), 32'(WAIT));
                end
            end else begin
                check("rdata_idle", resp_rdata, 32'd0);
            end
        end
    end

    // Present a request and hold it until accepted; req_valid is left high
    task automatic send(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input bit push, output int acc);
        int waited = 0;
        req_valid  = 1'b1;
        req_wr     = wr;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        while (!req_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            acc = -1;
        end else begin
            acc = cyc + 1;
            if (push) sb.push_back('{exp_rdata, exp_err, acc});
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int acc;
        send(wr, addr, size, sgn, wdata, exp_rdata, exp_err, 1'b1, acc);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int a1, a2, waited;
        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_size = '0;
        req_signed = 1'b0; req_wdata = '0;
        z_req_valid = 1'b0; z_req_wr = 1'b0; z_req_addr = '0; z_req_size = '0;
        z_req_signed = 1'b0; z_req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store/load and sub-word extraction
        issue(1, 32'h10, 2'b11, 0, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 32'h10, 2'b11, 0, 32'h0, 32'hDEADBEEF, 0);
        issue(0, 32'h10, 2'b00, 1, 32'h0, 32'hFFFFFFDE, 0);
        issue(0, 32'h13, 2'b00, 0, 32'h0, 32'h000000EF, 0);
        issue(0, 32'h12, 2'b01, 1, 32'h0, 32'hFFFFBEEF, 0);
        issue(0, 32'h10, 2'b01, 0, 32'h0, 32'h0000DEAD, 0);
        issue(1, 32'h11, 2'b00, 0, 32'h00000055, 32'h0, 0);
        issue(0, 32'h10, 2'b11, 0, 32'h0, 32'hDE55BEEF, 0);

        // Error cases, then readback shows memory untouched
        issue(0, 32'h12, 2'b11, 0, 32'h0, 32'h0, 1);
        issue(1, 32'h11, 2'b01, 0, 32'h0000FFFF, 32'h0, 1);
        issue(1, 32'h10, 2'b10, 0, 32'h11111111, 32'h0, 1);
        issue(0, DEPTH * 4, 2'b11, 0, 32'h0, 32'h0, 1);
        issue(0, 32'h10, 2'b11, 0, 32'h0, 32'hDE55BEEF, 0);

        // Halfword store to the low half, then signed byte loads of both polarities
        issue(1, 32'h12, 2'b01, 0, 32'hAAAA1234, 32'h0, 0);
        issue(0, 32'h10, 2'b11, 0, 32'h0, 32'hDE551234, 0);
        issue(0, 32'h13, 2'b00, 1, 32'h0, 32'h00000034, 0);
        issue(0, 32'h11, 2'b00, 1, 32'h0, 32'h00000055, 0);
        drain();

        // req_valid held high: second request only taken the cycle after RESP
        send(0, 32'h10, 2'b11, 0, 32'h0, 32'hDE551234, 0, 1'b1, a1);
        send(0, 32'h12, 2'b00, 0, 32'h0, 32'h00000012, 0, 1'b1, a2);
        req_valid = 1'b0;
        check("throughput", 32'(a2 - a1), 32'(WAIT + 2));
        drain();

        // Reset during the last wait cycle of a store drops it
        issue(1, 32'h20, 2'b11, 0, 32'hA5A50F0F, 32'h0, 0);
        send(1, 32'h20, 2'b11, 0, 32'h12345678, 32'h0, 0, 1'b0, a1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        issue(0, 32'h20, 2'b11, 0, 32'h0, 32'hA5A50F0F, 0);
        drain();

        // Zero-wait instance: back-to-back store/load every two cycles
        waited = 0;
        while (!z_req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("z_ready", 32'(z_req_ready), 32'd1);
        z_req_valid = 1'b1; z_req_wr = 1'b1; z_req_addr = 32'h4;
        z_req_size = 2'b11; z_req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("z_st_valid", 32'(z_resp_valid), 32'd1);
        check("z_st_err", 32'(z_resp_err), 32'd0);
        check("z_st_rdata", z_resp_rdata, 32'd0);
        check("z_busy", 32'(z_req_ready), 32'd0);
        z_req_wr = 1'b0;
        @(posedge clk); #1;
        check("z_gap_valid", 32'(z_resp_valid), 32'd0);
        check("z_gap_ready", 32'(z_req_ready), 32'd1);
        @(posedge clk); #1;
        check("z_ld_valid", 32'(z_resp_valid), 32'd1);
        check("z_ld_rdata", z_resp_rdata, 32'hCAFEF00D);
        z_req_addr = 32'h7; z_req_size = 2'b00; z_req_signed = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("z_lb_valid", 32'(z_resp_valid), 32'd1);
        check("z_lb_rdata", z_resp_rdata, 32'h0000000D);
        z_req_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
